// File: rtl/vram_scan_arbiter_if.sv
// vram_scan_arbiter_if: writer handshake plus single-port VRAM bus
interface vram_scan_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int WORD_W = 16
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;
    modport slave (
        input  wr_valid, wr_addr, wr_data, mem_rdata,
        output wr_ready, mem_addr, mem_we, mem_wdata
    );
    modport master (
        output wr_valid, wr_addr, wr_data, mem_rdata,
        input  wr_ready, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/vram_scan_arbiter.sv
// vram_scan_arbiter: shares a single-port VRAM between display line prefetch and a drawing writer
module vram_scan_arbiter #(
    parameter int H_TOTAL    = 800,
    parameter int V_TOTAL    = 525,
    parameter int H_VISIBLE  = 640,
    parameter int V_VISIBLE  = 480,
    parameter int PIX_W      = 2,
    parameter int WORD_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int FETCH_LEAD = 16
) (
    input  logic             pixel_clk,
    input  logic             reset,
    input  logic [9:0]       row,
    input  logic [9:0]       col,
    input  logic             visible,
    vram_scan_arbiter_if.slave bus,
    output logic [PIX_W-1:0] pix_data,
    output logic             pix_valid,
    output logic             underflow,
    input  logic             underflow_clr
);
    localparam int PIX_PER_WORD   = WORD_W / PIX_W;
    localparam int WORDS_PER_LINE = H_VISIBLE / PIX_PER_WORD;
    localparam int SEL_W          = $clog2(PIX_PER_WORD);
    localparam int PTR_W          = $clog2(FIFO_DEPTH);
    localparam int OCC_W          = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W          = $clog2(WORDS_PER_LINE + 1);
    localparam logic [9:0] TRIG_ROW   = 10'(H_TOTAL - FETCH_LEAD);
    localparam logic [9:0] LAST_COL   = 10'(V_TOTAL - 1);
    localparam logic [9:0] FETCH_LIM  = 10'(V_VISIBLE - 1);

    typedef enum logic {IDLE, FETCH} state_t;

    state_t            state;
    logic [WORD_W-1:0] fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ;
    logic              in_flight;
    logic [ADDR_W-1:0] fetch_addr;
    logic [CNT_W-1:0]  words;
    logic [WORD_W-1:0] hold;
    logic [WORD_W-1:0] head;
    logic [SEL_W-1:0]  pix_sel;
    logic              trigger;
    logic              frame_start;
    logic              issue;
    logic              push;
    logic              pop;
    logic              empty;

    always_comb begin
        frame_start   = row == TRIG_ROW && col == LAST_COL;
        trigger       = row == TRIG_ROW && (col == LAST_COL || col < FETCH_LIM);
        issue         = state == FETCH && (occ + OCC_W'(in_flight)) < OCC_W'(FIFO_DEPTH);
        empty         = occ == '0;
        push          = in_flight && !frame_start;
        pix_sel       = row[SEL_W-1:0];
        pop           = visible && pix_sel == '0;
        head          = fifo[rd_ptr];
        bus.wr_ready  = !issue;
        bus.mem_addr  = issue ? fetch_addr : bus.wr_addr;
        bus.mem_we    = !issue && bus.wr_valid;
        bus.mem_wdata = bus.wr_data;
    end

    always_ff @(posedge pixel_clk) begin
        if (push) fifo[wr_ptr] <= bus.mem_rdata;
    end

    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            in_flight  <= 1'b0;
            fetch_addr <= '0;
            words      <= '0;
            hold       <= '0;
            pix_data   <= '0;
            pix_valid  <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            // a frame-start trigger is the recovery point: stale words and the read in the air are dropped
            in_flight <= issue && !frame_start;
            if (frame_start) begin
                fetch_addr <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                occ        <= '0;
            end else begin
                if (issue) fetch_addr <= fetch_addr + ADDR_W'(1);
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop && !empty) rd_ptr <= rd_ptr + PTR_W'(1);
                occ <= occ + OCC_W'(push) - OCC_W'(pop && !empty);
            end
            if (trigger) begin
                state <= FETCH;
                words <= '0;
            end else if (issue) begin
                words <= words + CNT_W'(1);
                if (words == CNT_W'(WORDS_PER_LINE - 1)) state <= IDLE;
            end
            pix_valid <= visible;
            if (pop) hold <= empty ? '0 : head;
            pix_data  <= !visible ? '0 : pop ? (empty ? '0 : head[PIX_W-1:0]) : hold[PIX_W*pix_sel +: PIX_W];
            underflow <= (pop && empty) || (underflow && !underflow_clr);
        end
    end
endmodule

// File: tb/tb_vram_scan_arbiter.sv
// tb_vram_scan_arbiter: directed scan/writer stimulus with queue scoreboards for pixels, reads and writes
module tb_vram_scan_arbiter;
    typedef struct {logic [1:0] p; logic uf;} pix_t;
    typedef struct {logic [15:0] addr; logic [9:0] r; logic [9:0] c;} rd_t;
    typedef struct {logic [15:0] addr; logic [15:0] data;} wr_t;

    logic       pixel_clk = 0;
    logic       reset = 0;
    logic [9:0] row = 0;
    logic [9:0] col = 0;
    logic       visible = 0;
    logic       underflow_clr = 0;
    logic [1:0] pix_data;
    logic       pix_valid;
    logic       underflow;
    logic [15:0] ram [0:65535];
    logic [1:0] hand0 [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};

    pix_t exp_pix[$];
    rd_t  exp_rd[$];
    wr_t  exp_wr[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   uf_exp = 0;
    bit   wr_on = 0;
    int   wbase = 0;
    int   wr_n = 0;

    vram_scan_arbiter_if #(.ADDR_W(16), .WORD_W(16)) bus ();

    vram_scan_arbiter dut (
        .pixel_clk     (pixel_clk),
        .reset         (reset),
        .row           (row),
        .col           (col),
        .visible       (visible),
        .bus           (bus),
        .pix_data      (pix_data),
        .pix_valid     (pix_valid),
        .underflow     (underflow),
        .underflow_clr (underflow_clr)
    );

    always #5 pixel_clk = ~pixel_clk;

    always @(posedge pixel_clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    function automatic logic [15:0] img(input int a);
        return a == 0 ? 16'h00E4 : 16'(a * 40503 + 12345);
    endfunction

    function automatic logic [1:0] pix_of(input int c, input int r);
        logic [15:0] w;
        if (c == 0 && r < 8) return hand0[r];
        w = img(c * 80 + r / 8);
        return 2'(w >> (2 * (r % 8)));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (row %0d col %0d t=%0t)", name, act, exp, row, col, $time);
        end
    endtask

    task automatic miss(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: DUT output with no expected entry (row %0d col %0d t=%0t)", name, row, col, $time);
    endtask

    task automatic push_fetch(input int tc, input int n);
        int ln;
        ln = tc == 524 ? 0 : tc + 1;
        for (int k = 0; k < n; k++)
            exp_rd.push_back(k < 4 ? rd_t'{16'(ln * 80 + k), 10'(785 + k), 10'(tc)}
                                   : rd_t'{16'(ln * 80 + k), 10'(8 * (k - 4) + 1), 10'(ln)});
    endtask

    task automatic step(input int r, input int c, input bit clr = 1'b0);
        bit acc;
        row = 10'(r);
        col = 10'(c);
        visible = r < 640 && c < 480;
        underflow_clr = clr;
        if (r < 640 && c < 480) exp_pix.push_back('{uf_exp ? 2'd0 : pix_of(c, r), uf_exp});
        if (wr_on && !bus.wr_valid) begin
            bus.wr_valid = 1;
            bus.wr_addr = 16'(wbase + wr_n);
            bus.wr_data = 16'(wr_n) ^ 16'hA5A5;
            exp_wr.push_back('{bus.wr_addr, bus.wr_data});
            wr_n++;
        end
        @(negedge pixel_clk);
        acc = bus.wr_valid && bus.wr_ready;
        @(posedge pixel_clk);
        #1;
        if (acc) bus.wr_valid = 0;
    endtask

    always @(negedge pixel_clk) begin
        if (pix_valid) begin
            if (exp_pix.size() == 0) miss("pix");
            else begin
                pix_t e;
                e = exp_pix.pop_front();
                chk("pix_data", pix_data, e.p);
                chk("underflow", underflow, e.uf);
            end
        end
        if (bus.mem_we) begin
            if (exp_wr.size() == 0) miss("write");
            else begin
                wr_t w;
                w = exp_wr.pop_front();
                chk("wr_addr", bus.mem_addr, w.addr);
                chk("wr_data", bus.mem_wdata, w.data);
                chk("wr_ready_on_write", bus.wr_ready, 1);
            end
        end else if (bus.wr_valid || !bus.wr_ready) begin
            if (exp_rd.size() == 0) miss("read");
            else begin
                rd_t d;
                d = exp_rd.pop_front();
                chk("rd_addr", bus.mem_addr, d.addr);
                chk("rd_row", row, d.r);
                chk("rd_col", col, d.c);
                chk("wr_ready_on_read", bus.wr_ready, 0);
            end
        end
    end

    initial begin
        bus.wr_valid = 0;
        bus.wr_addr = 0;
        bus.wr_data = 0;
        for (int i = 0; i < 65536; i++) ram[i] = img(i);
        row = 700;
        repeat (3) @(posedge pixel_clk);
        #1;
        chk("rst_pix_data", pix_data, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_wr_ready", bus.wr_ready, 1);
        chk("rst_mem_we", bus.mem_we, 0);

        // release at the first visible pixel with nothing prefetched
        reset = 1;
        uf_exp = 1;
        for (int r = 0; r < 640; r++) step(r, 0);
        step(700, 0, 1'b1);
        chk("uf_clear", underflow, 0);
        step(0, 1, 1'b1);
        for (int r = 1; r < 8; r++) step(r, 1);
        step(700, 1);
        chk("uf_set_wins", underflow, 1);

        // reset in the middle of a frame-start fetch
        uf_exp = 0;
        push_fetch(524, 4);
        for (int r = 784; r < 790; r++) step(r, 524);
        row = 790;
        #1 reset = 0;
        #1;
        chk("rst_mid_pix_data", pix_data, 0);
        chk("rst_mid_pix_valid", pix_valid, 0);
        chk("rst_mid_underflow", underflow, 0);
        chk("rst_mid_wr_ready", bus.wr_ready, 1);
        @(posedge pixel_clk);
        #1 reset = 1;
        chk("post_rst_wr_ready", bus.wr_ready, 1);
        for (int r = 791; r < 800; r++) step(r, 524);

        // frame prefetch and active lines under constant writer pressure
        wbase = 40000;
        wr_n = 0;
        wr_on = 1;
        push_fetch(524, 80);
        for (int r = 784; r < 800; r++) step(r, 524);
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 640; r++) step(r, c);
            if (c < 3) begin
                push_fetch(c, 80);
                for (int r = 784; r < 800; r++) step(r, c);
            end
        end
        wr_on = 0;
        for (int i = 0; i < 4; i++) step(700, 3);
        chk("line_reads_done", exp_rd.size(), 0);
        chk("uf_after_frame", underflow, 0);

        // vertical blanking: writer owns every slot
        wbase = 100;
        wr_n = 0;
        wr_on = 1;
        for (int r = 0; r < 32; r++) step(r, 500);
        wr_on = 0;
        for (int i = 0; i < 4; i++) step(700, 500);
        chk("vblank_writes", wr_n, 32);
        chk("ram_written", ram[131], 16'(31) ^ 16'hA5A5);

        chk("pix_queue_empty", exp_pix.size(), 0);
        chk("rd_queue_empty", exp_rd.size(), 0);
        chk("wr_queue_empty", exp_wr.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
